// File: rtl/lfsr_checker.sv
// Purpose: seeds a local x^16+x^15+x^13+x^4+1 LFSR from the received stream, then checks each following bit.
// Latency: err and the counters update 1 cycle after the checked bit; locked rises 1 cycle after the 16th seed bit.
// Backpressure: none. One bit per cycle, and in_valid=0 cycles leave all state unchanged.
module lfsr_checker #(
  parameter int CNT_W       = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             sync_lost
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    ST_SEED   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] sr;
  logic [3:0]  seed_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;

  logic          exp_bit;
  logic          mis;
  logic [15:0]   seed_sr;
  logic          seed_done;
  logic          wrap;
  logic [EW-1:0] win_err_nxt;
  logic          loss;
  logic          check;

  // Prediction, mismatch and window arithmetic for the current bit.
  // The wrapping bit opens the new window, so its mismatch seeds win_err.
  always_comb begin
    exp_bit     = sr[15] ^ sr[14] ^ sr[12] ^ sr[3];
    mis         = in_bit ^ exp_bit;
    seed_sr     = {sr[14:0], in_bit};
    seed_done   = (seed_cnt == 4'd15);
    wrap        = (win_cnt == WW'(WINDOW - 1));
    win_err_nxt = wrap ? EW'(mis) : (win_err + EW'(mis));
    loss        = mis && (win_err_nxt == EW'(LOSS_THRESH));
    check       = (state == ST_LOCKED) && in_valid && !clr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_SEED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: lock after a non-zero 16-bit seed, fall back to seeding on loss or clr.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_SEED;
    end else if (in_valid) begin
      case (state)
        ST_SEED:   if (seed_done && (seed_sr != 16'h0000)) state_nxt = ST_LOCKED;
        ST_LOCKED: if (loss) state_nxt = ST_SEED;
        default:   state_nxt = ST_SEED;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Shift register, seed counter, loss window and error/bit counters.
  // While locked, the LFSR free-runs on its own prediction, so a single
  // corrupted bit produces one error instead of propagating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      sync_lost <= 1'b0;
    end else if (clr) begin
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
      sync_lost <= 1'b0;
    end else begin
      err <= check & mis;
      if (in_valid) begin
        if (state == ST_SEED) begin
          sr       <= seed_sr;
          seed_cnt <= seed_done ? 4'd0 : (seed_cnt + 4'd1);
        end else begin
          sr <= {sr[14:0], exp_bit};
          if (bit_count != {CNT_W{1'b1}}) begin
            bit_count <= bit_count + CNT_W'(1);
          end
          if (mis && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
          end
          if (loss) begin
            win_cnt   <= '0;
            win_err   <= '0;
            seed_cnt  <= '0;
            sync_lost <= 1'b1;
          end else begin
            win_cnt <= wrap ? '0 : (win_cnt + WW'(1));
            win_err <= win_err_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed stimulus against a queue-based reference model of the checker.
// Expected results are queued per accepted bit and compared one cycle later by a monitor.
// Counter width is narrowed to 8 bits here so saturation is reachable in a short run.
module tb_lfsr_checker;

  localparam int CW   = 8;
  localparam int WIN  = 64;
  localparam int LT   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_count;
  logic [CW-1:0] bit_count;
  logic          sync_lost;

  always #5 clk = ~clk;

  lfsr_checker #(.CNT_W(CW), .WINDOW(WIN), .LOSS_THRESH(LT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count),
    .sync_lost (sync_lost)
  );

  typedef struct {
    bit err;
    bit locked;
    int errc;
    int bitc;
    bit slost;
  } rec_t;

  rec_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pulses = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of seed bits, then a sliding history of the last 16 sequence bits.
  bit m_locked;
  bit m_seed[$];
  bit m_hist[$];
  int m_widx, m_werr, m_errc, m_bitc;
  bit m_slost;

  function automatic void model_clear();
    m_locked = 0; m_seed.delete(); m_hist.delete();
    m_widx = 0; m_werr = 0; m_errc = 0; m_bitc = 0; m_slost = 0;
  endfunction

  function automatic rec_t model_step(input bit b);
    rec_t r;
    bit   mis = 0;
    bit   e;
    bit   any = 0;
    if (!m_locked) begin
      m_seed.push_back(b);
      if (m_seed.size() == 16) begin
        foreach (m_seed[k]) any |= m_seed[k];
        if (any) begin
          m_locked = 1;
          m_hist   = m_seed;
        end
        m_seed.delete();
      end
    end else begin
      e = m_hist[0] ^ m_hist[1] ^ m_hist[3] ^ m_hist[12];
      void'(m_hist.pop_front());
      m_hist.push_back(e);
      mis = b ^ e;
      if (m_bitc < MAXC) m_bitc++;
      if (mis && m_errc < MAXC) m_errc++;
      if (m_widx == WIN - 1) begin
        m_widx = 0;
        m_werr = int'(mis);
      end else begin
        m_widx++;
        m_werr += int'(mis);
      end
      if (mis && m_werr == LT) begin
        m_locked = 0; m_slost = 1; m_widx = 0; m_werr = 0;
      end
    end
    r.err = mis; r.locked = m_locked; r.errc = m_errc; r.bitc = m_bitc; r.slost = m_slost;
    return r;
  endfunction

  // Generator reference: seed MSB-first, then b[n] = b[n-16]^b[n-15]^b[n-13]^b[n-4].
  bit strm[$];
  int flips[$];

  function automatic void gen(input logic [15:0] seed, input int n);
    strm.delete();
    for (int i = 0; i < 16; i++) strm.push_back(seed[15-i]);
    for (int i = 16; i < n; i++) strm.push_back(strm[i-16] ^ strm[i-15] ^ strm[i-13] ^ strm[i-4]);
  endfunction

  function automatic bit flipped(input int i);
    foreach (flips[k]) if (flips[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit b, input int gap);
    repeat (gap) begin
      @(negedge clk); in_valid = 1'b0; in_bit = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1; in_bit = b;
    sbq.push_back(model_step(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); in_valid = 1'b0;
    end
  endtask

  task automatic play(input int first, input int last, input int gap);
    for (int i = first; i < last; i++) drive(strm[i] ^ flipped(i), gap);
    idle(2);
  endtask

  // Synchronous clear issued together with a valid bit, which must be discarded.
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_bit = 1'($urandom);
    model_clear();
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
  endtask

  // Monitor: one queued record per accepted bit, compared one cycle after it.
  always begin
    bit   v;
    rec_t r;
    @(posedge clk);
    v = in_valid & ~clr & rst;
    #1;
    if (err) n_pulses++;
    if (v) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        r = sbq.pop_front();
        chk("err", err, r.err);
        chk("locked", locked, r.locked);
        chk("err_count", err_count, r.errc);
        chk("bit_count", bit_count, r.bitc);
        chk("sync_lost", sync_lost, r.slost);
      end
    end else if (rst) begin
      chk("err_idle", err, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int t;
    logic [15:0] rseed;
    model_clear();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_sync_lost", sync_lost, 0);
    rst = 1'b1;

    // 1: clean stream
    gen(16'hACE1, 600);
    play(0, 116, 0);
    chk("t1_bit_count", bit_count, 100);
    chk("t1_err_count", err_count, 0);
    chk("t1_locked", locked, 1);
    chk("t1_pulses", n_pulses, 0);

    // 2: single inverted checked bit
    do_clr();
    chk("clr_bit_count", bit_count, 0);
    chk("clr_locked", locked, 0);
    flips = '{16 + 40};
    p0 = n_pulses;
    play(0, 116, 0);
    chk("t2_pulses", n_pulses - p0, 1);
    chk("t2_err_count", err_count, 1);
    chk("t2_bit_count", bit_count, 100);
    chk("t2_locked", locked, 1);

    // 3: four errors in one window force resync, then relock
    do_clr();
    flips = '{26, 36, 46, 56};
    play(0, 57, 0);
    chk("t3_locked_lost", locked, 0);
    chk("t3_sync_lost", sync_lost, 1);
    chk("t3_err_count", err_count, 4);
    play(57, 73, 0);
    chk("t3_relocked", locked, 1);
    chk("t3_sync_sticky", sync_lost, 1);
    play(73, 121, 0);
    chk("t3_err_count_end", err_count, 4);
    chk("t3_bit_count_end", bit_count, 89);

    // 4: three errors at window end, one after wrap
    do_clr();
    flips = '{16 + 60, 16 + 61, 16 + 62, 16 + 66};
    play(0, 116, 0);
    chk("t4_locked", locked, 1);
    chk("t4_err_count", err_count, 4);
    chk("t4_sync_lost", sync_lost, 0);

    // 5: all-zero seed is rejected
    do_clr();
    flips.delete();
    for (int i = 0; i < 16; i++) drive(1'b0, 0);
    idle(2);
    chk("t5_zero_seed", locked, 0);
    play(0, 116, 0);
    chk("t5_locked", locked, 1);
    chk("t5_bit_count", bit_count, 100);

    // 6: gapped stream, clr mid-stream, async reset mid-stream
    do_clr();
    play(0, 116, 2);
    chk("t6_gap_bit_count", bit_count, 100);
    chk("t6_gap_err_count", err_count, 0);
    do_clr();
    play(0, 50, 0);
    do_clr();
    chk("t6_clr_bit_count", bit_count, 0);
    chk("t6_clr_locked", locked, 0);
    play(0, 40, 0);
    chk("t6_pre_rst_locked", locked, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_bit_count", bit_count, 0);
    chk("t6_rst_sync_lost", sync_lost, 0);
    model_clear();
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;

    // Random: random seed, sparse random errors and gaps, long enough to saturate counters
    rseed = 16'($urandom_range(1, 65535));
    gen(rseed, 1100);
    for (int i = 0; i < 1100; i++) begin
      drive(strm[i] ^ ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    idle(2);
    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
